nn_sample_sequencer: RTL and testbench

- Sits around the 2-input/2-hidden/1-output neuron network. Upstream, it buffers labelled input samples from a valid/ready source and drives each sample to the network's 2-bit inputs.
- It holds the inputs stable for a settle window, then samples the network output as a fixed-point value.
- It thresholds that value into a binary prediction, scores it against the label, and emits one result per sample on a valid/ready port.
- It keeps running sample and correct-prediction counters.

---
 rtl/nn_sample_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_nn_sample_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_sample_sequencer.sv
// nn_sample_sequencer: feeds labelled samples from a small FIFO into the
// 2-2-1 neuron network, waits a settle window, captures and thresholds the
// network output, scores it against the label and emits one result per
// sample. Keeps saturating sample / correct-prediction counters.
// Optional macro NN_SEQ_CONF_EN adds r_margin / r_lowconf confidence outputs.
module nn_sample_sequencer #(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter int unsigned OUT_W         = 8,
   parameter int unsigned THRESH        = 2 ** (OUT_W - 2),
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [1:0]       s_in1,
   input  logic [1:0]       s_in2,
   input  logic             s_label,
   output logic [1:0]       nn_in1,
   output logic [1:0]       nn_in2,
   input  logic [OUT_W-1:0] nn_out,
   output logic             r_valid,
   input  logic             r_ready,
   output logic             r_pred,
   output logic             r_label,
   output logic             r_correct,
   output logic [OUT_W-1:0] r_score,
`ifdef NN_SEQ_CONF_EN
   output logic [OUT_W-1:0] r_margin,
   output logic             r_lowconf,
`endif
   output logic             busy,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] correct_cnt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned SW = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [OUT_W-1:0] THRESH_V    = OUT_W'(THRESH);
   localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, CAPTURE = 2'd2, EMIT = 2'd3} state_t;

   state_t          state, state_next;
   logic [4:0]      mem [FIFO_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            empty, full, wr_en, pop, capture, accept;
   logic [4:0]      head;
   logic            label_hold;
   logic [SW-1:0]   settle_cnt;
   logic            pred_now;

   // FIFO occupancy flags; the pointer MSB separates full from empty
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign s_ready = !full;
   assign wr_en   = s_valid && !full;
   assign head    = mem[rd_ptr[AW-1:0]];
   assign busy    = (state != IDLE) || !empty;
   assign pred_now = (nn_out >= THRESH_V);

   // FIFO storage; contents need no reset because the pointers gate them
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= {s_label, s_in2, s_in1};
      end
   end

   // FIFO pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Next-state logic and per-cycle strobes for pop / capture / accept
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      capture    = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = SETTLE;
            end else begin
               state_next = IDLE;
            end
         end
         SETTLE: begin
            if (settle_cnt == '0) state_next = CAPTURE;
            else                  state_next = SETTLE;
         end
         CAPTURE: begin
            capture    = 1'b1;
            state_next = EMIT;
         end
         EMIT: begin
            if (r_ready) begin
               accept = 1'b1;
               if (!empty) begin
                  pop        = 1'b1;
                  state_next = SETTLE;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               state_next = EMIT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Network drive, held label and settle countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nn_in1     <= 2'b00;
         nn_in2     <= 2'b00;
         label_hold <= 1'b0;
         settle_cnt <= '0;
      end else if (pop) begin
         nn_in1     <= head[1:0];
         nn_in2     <= head[3:2];
         label_hold <= head[4];
         settle_cnt <= SETTLE_LOAD;
      end else if (state == SETTLE && settle_cnt != '0) begin
         settle_cnt <= settle_cnt - 1'b1;
      end else begin
         settle_cnt <= settle_cnt;
      end
   end

   // Result registers: loaded on capture, held until accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_pred    <= 1'b0;
         r_label   <= 1'b0;
         r_correct <= 1'b0;
         r_score   <= '0;
      end else if (capture) begin
         r_valid   <= 1'b1;
         r_pred    <= pred_now;
         r_label   <= label_hold;
         r_correct <= (pred_now == label_hold);
         r_score   <= nn_out;
      end else if (accept) begin
         r_valid   <= 1'b0;
      end else begin
         r_valid   <= r_valid;
      end
   end

`ifdef NN_SEQ_CONF_EN
   localparam logic [OUT_W-1:0] LOWCONF_LIM = OUT_W'(2 ** (OUT_W - 4));
   logic [OUT_W-1:0] margin_now;
   assign margin_now = pred_now ? (nn_out - THRESH_V) : (THRESH_V - nn_out);

   // Confidence outputs, captured alongside the score
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_margin  <= '0;
         r_lowconf <= 1'b0;
      end else if (capture) begin
         r_margin  <= margin_now;
         r_lowconf <= (margin_now < LOWCONF_LIM);
      end else begin
         r_margin  <= r_margin;
      end
   end
`endif

   // Saturating statistics counters; clear takes priority over acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt  <= '0;
         correct_cnt <= '0;
      end else if (clr_cnt) begin
         sample_cnt  <= '0;
         correct_cnt <= '0;
      end else if (accept) begin
         if (sample_cnt != '1)               sample_cnt  <= sample_cnt + 1'b1;
         if (r_correct && correct_cnt != '1) correct_cnt <= correct_cnt + 1'b1;
      end else begin
         sample_cnt  <= sample_cnt;
      end
   end

endmodule

// File: tb/tb_nn_sample_sequencer.sv
// Scoreboard bench for nn_sample_sequencer. A second instance with 2-bit
// counters shares all inputs so counter saturation is reached quickly.
module tb_nn_sample_sequencer;

   typedef struct packed {
      logic       pred;
      logic       label;
      logic       correct;
      logic [7:0] score;
      logic [7:0] margin;
      logic       lowconf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_valid = 1'b0, r_ready = 1'b0, clr_cnt = 1'b0, s_label = 1'b0;
   logic [1:0] s_in1 = 2'b00, s_in2 = 2'b00;
   logic       s_ready, r_valid, r_pred, r_label, r_correct, busy;
   logic [1:0] nn_in1, nn_in2;
   logic [7:0] nn_out, r_score;
   logic [15:0] sample_cnt, correct_cnt;
   logic       b_s_ready, b_r_valid, b_r_pred, b_r_label, b_r_correct, b_busy;
   logic [1:0] b_nn_in1, b_nn_in2, b_sample_cnt, b_correct_cnt;
   logic [7:0] b_nn_out, b_r_score;
`ifdef NN_SEQ_CONF_EN
   logic [7:0] r_margin, b_r_margin;
   logic       r_lowconf, b_r_lowconf;
`endif

   logic [7:0] lut [16];
   exp_t       exp_q [$];
   int         tests = 0, fails = 0;
   int         m_samp = 0, m_corr = 0, mb_samp = 0, mb_corr = 0;

   // Behavioural stand-in for the network: output looked up from its inputs
   assign nn_out   = lut[{nn_in1, nn_in2}];
   assign b_nn_out = lut[{b_nn_in1, b_nn_in2}];

   always #5 clk = ~clk;

   nn_sample_sequencer dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_in1(s_in1), .s_in2(s_in2), .s_label(s_label),
      .nn_in1(nn_in1), .nn_in2(nn_in2), .nn_out(nn_out),
      .r_valid(r_valid), .r_ready(r_ready), .r_pred(r_pred), .r_label(r_label),
      .r_correct(r_correct), .r_score(r_score),
`ifdef NN_SEQ_CONF_EN
      .r_margin(r_margin), .r_lowconf(r_lowconf),
`endif
      .busy(busy), .clr_cnt(clr_cnt), .sample_cnt(sample_cnt), .correct_cnt(correct_cnt));

   nn_sample_sequencer #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(b_s_ready),
      .s_in1(s_in1), .s_in2(s_in2), .s_label(s_label),
      .nn_in1(b_nn_in1), .nn_in2(b_nn_in2), .nn_out(b_nn_out),
      .r_valid(b_r_valid), .r_ready(r_ready), .r_pred(b_r_pred), .r_label(b_r_label),
      .r_correct(b_r_correct), .r_score(b_r_score),
`ifdef NN_SEQ_CONF_EN
      .r_margin(b_r_margin), .r_lowconf(b_r_lowconf),
`endif
      .busy(b_busy), .clr_cnt(clr_cnt), .sample_cnt(b_sample_cnt), .correct_cnt(b_correct_cnt));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: counter model check every cycle, scoreboard pop on each accepted result
   always @(negedge clk) begin
      if (!rst_n) begin
         m_samp = 0; m_corr = 0; mb_samp = 0; mb_corr = 0;
      end else begin
         exp_t e;
         logic acc;
         chk("sample_cnt", 32'(sample_cnt), 32'(m_samp));
         chk("correct_cnt", 32'(correct_cnt), 32'(m_corr));
         chk("sat_sample_cnt", 32'(b_sample_cnt), 32'(mb_samp));
         chk("sat_correct_cnt", 32'(b_correct_cnt), 32'(mb_corr));
         acc = r_valid && r_ready;
         e = '0;
         if (acc) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("r_score", 32'(r_score), 32'(e.score));
               chk("r_pred", 32'(r_pred), 32'(e.pred));
               chk("r_label", 32'(r_label), 32'(e.label));
               chk("r_correct", 32'(r_correct), 32'(e.correct));
`ifdef NN_SEQ_CONF_EN
               chk("r_margin", 32'(r_margin), 32'(e.margin));
               chk("r_lowconf", 32'(r_lowconf), 32'(e.lowconf));
`endif
            end
         end
         if (clr_cnt) begin
            m_samp = 0; m_corr = 0; mb_samp = 0; mb_corr = 0;
         end else if (acc) begin
            if (m_samp < 65535) m_samp++;
            if (mb_samp < 3) mb_samp++;
            if (e.correct && m_corr < 65535) m_corr++;
            if (e.correct && mb_corr < 3) mb_corr++;
         end
      end
   end

   // Offer one sample; called and returns just after a rising edge
   task automatic send(input logic [1:0] a, input logic [1:0] b, input logic lab);
      logic rdy;
      exp_t e;
      s_in1 = a; s_in2 = b; s_label = lab; s_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk); rdy = s_ready;
         @(posedge clk); #1;
         if (rdy) begin
            e.score   = lut[{a, b}];
            e.pred    = (e.score >= 8'h40);
            e.label   = lab;
            e.correct = (e.pred == lab);
            e.margin  = e.pred ? (e.score - 8'h40) : (8'h40 - e.score);
            e.lowconf = (e.margin < 8'h10);
            exp_q.push_back(e);
            s_valid = 1'b0;
            return;
         end
      end
      chk("send_timeout", 32'd1, 32'd0);
      s_valid = 1'b0;
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && !busy && !r_valid) return;
      end
      chk("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_valid();
      for (int k = 0; k < 100; k++) begin
         if (r_valid) return;
         @(posedge clk); #1;
      end
      chk("valid_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 16; i++) lut[i] = 8'(i * 15);
      lut[4'b0000] = 8'h40; lut[4'b0001] = 8'h3F; lut[4'b0010] = 8'h44;
      lut[4'b0011] = 8'h70; lut[4'b0110] = 8'h50; lut[4'b1111] = 8'h10;
      lut[4'b1001] = 8'h20;

      // Reset state
      #12;
      chk("rst_r_valid", 32'(r_valid), 32'd0);
      chk("rst_nn_in", 32'({nn_in1, nn_in2}), 32'd0);
      chk("rst_r_fields", 32'({r_pred, r_label, r_correct, r_score}), 32'd0);
      chk("rst_cnts", 32'({sample_cnt, correct_cnt}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      chk("rst_s_ready", 32'(s_ready), 32'd1);

      // One sample: drive on the pop edge, result SETTLE_CYCLES+1 clocks later
      r_ready = 1'b1;
      send(2'b01, 2'b10, 1'b1);
      step(1);
      chk("pop_nn_in1", 32'(nn_in1), 32'h1);
      chk("pop_nn_in2", 32'(nn_in2), 32'h2);
      for (int k = 0; k < 3; k++) begin
         step(1);
         chk("latency_not_yet", 32'(r_valid), 32'd0);
      end
      step(1);
      chk("latency_valid", 32'(r_valid), 32'd1);
      wait_drain();
      chk("one_sample_cnt", 32'(sample_cnt), 32'd1);
      chk("one_correct_cnt", 32'(correct_cnt), 32'd1);

      // Threshold boundary 0x40 / 0x3F
      send(2'b00, 2'b00, 1'b1);
      wait_drain();
      send(2'b00, 2'b01, 1'b1);
      wait_drain();
      chk("idle_holds_nn_in", 32'({nn_in1, nn_in2}), 32'h1);

      // FIFO full and backpressure
      r_ready = 1'b0;
      send(2'b01, 2'b10, 1'b0);
      send(2'b00, 2'b10, 1'b1);
      send(2'b00, 2'b11, 1'b1);
      send(2'b11, 2'b11, 1'b0);
      send(2'b10, 2'b01, 1'b1);
      chk("full_s_ready", 32'(s_ready), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      wait_valid();
      for (int k = 0; k < 20; k++) begin
         chk("hold_valid", 32'(r_valid), 32'd1);
         chk("hold_score", 32'(r_score), 32'(exp_q[0].score));
         chk("hold_pred_label", 32'({r_pred, r_label, r_correct}),
             32'({exp_q[0].pred, exp_q[0].label, exp_q[0].correct}));
         chk("hold_full", 32'(s_ready), 32'd0);
         step(1);
      end
      r_ready = 1'b1;
      wait_drain();
      chk("drain_cnt", 32'(sample_cnt), 32'd8);
      chk("drain_correct", 32'(correct_cnt), 32'd5);

      // Saturation (2-bit instance) and clear colliding with an acceptance
      chk("sat_sample_hold", 32'(b_sample_cnt), 32'h3);
      chk("sat_correct_hold", 32'(b_correct_cnt), 32'h3);
      r_ready = 1'b0;
      send(2'b00, 2'b11, 1'b1);
      wait_valid();
      r_ready = 1'b1; clr_cnt = 1'b1;
      step(1);
      clr_cnt = 1'b0;
      chk("clr_sample_cnt", 32'(sample_cnt), 32'd0);
      chk("clr_correct_cnt", 32'(correct_cnt), 32'd0);
      chk("clr_sat_cnt", 32'({b_sample_cnt, b_correct_cnt}), 32'd0);
      send(2'b00, 2'b10, 1'b1);
      wait_drain();
      chk("post_clr_cnt", 32'(sample_cnt), 32'd1);

      // Reset while a sample is settling
      send(2'b01, 2'b10, 1'b1);
      send(2'b00, 2'b11, 1'b0);
      step(1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_r_valid", 32'(r_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_cnt", 32'(sample_cnt), 32'd0);
      step(2);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         step(1);
         if (r_valid || busy) seen++;
      end
      chk("no_result_after_reset", 32'(seen), 32'd0);

`ifdef NN_SEQ_CONF_EN
      // Confidence outputs: 0x44 -> margin 4 low, 0x70 -> margin 0x30 high
      r_ready = 1'b0;
      send(2'b00, 2'b10, 1'b1);
      wait_valid();
      chk("conf_margin_44", 32'(r_margin), 32'h04);
      chk("conf_low_44", 32'(r_lowconf), 32'd1);
      r_ready = 1'b1;
      wait_drain();
      r_ready = 1'b0;
      send(2'b00, 2'b11, 1'b1);
      wait_valid();
      chk("conf_margin_70", 32'(r_margin), 32'h30);
      chk("conf_low_70", 32'(r_lowconf), 32'd0);
      r_ready = 1'b1;
      wait_drain();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
